// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// The registered request is sized at the default widths.
package ram_arb_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_AW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                 idx;
    logic                 we;
    logic [DEF_AW-1:0]    addr;
    logic [DEF_WIDTH-1:0] wdata;
  } req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. i_ptr is the index of the last winner, so the
// other requester wins when both are valid.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case (i_valid)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto a single synchronous RAM port.
// Each transaction takes three cycles: handshake, ACCESS, RESP.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0][AW-1:0]    req_addr,
  input  logic [1:0][WIDTH-1:0] req_wdata,
  output logic [1:0]            rsp_valid,
  output logic [1:0][WIDTH-1:0] rsp_rdata,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [WIDTH-1:0]      mem_din,
  input  logic [WIDTH-1:0]      mem_dout,
  output logic                  busy
);

  state_t                  r_state;
  state_t                  w_next;
  req_t                    r_req;
  logic                    r_ptr;
  logic [1:0][WIDTH-1:0]   r_rdata;
  logic [1:0]              w_gnt;
  logic [1:0]              w_ready;
  logic                    w_hs;
  logic                    w_win;

  rr_arb2 u_rr (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt)
  );

  // Grants only leave the arbiter while idle and out of reset.
  assign w_ready   = (r_state == IDLE && !rst) ? w_gnt : 2'b00;
  assign req_ready = w_ready;
  assign w_hs      = |w_ready;
  assign w_win     = w_ready[1];

  assign busy     = (r_state != IDLE);
  assign mem_addr = AW'(r_req.addr);
  assign mem_din  = WIDTH'(r_req.wdata);

  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    rsp_valid = 2'b00;
    case (r_state)
      IDLE: begin
        if (w_hs) w_next = ACCESS;
      end
      ACCESS: begin
        // Gating with rst keeps an aborted write from reaching the RAM.
        mem_we = r_req.we & ~rst;
        w_next = RESP;
      end
      RESP: begin
        rsp_valid[r_req.idx] = ~rst;
        w_next               = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Read data bypasses straight from the RAM during RESP, then is held.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rsp_rdata[i] = r_rdata[i];
      if (r_state == RESP && !rst && !r_req.we && r_req.idx == 1'(i))
        rsp_rdata[i] = mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b1;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_ptr       <= w_win;
        r_req.idx   <= w_win;
        r_req.we    <= req_we[w_win];
        r_req.addr  <= DEF_AW'(req_addr[w_win]);
        r_req.wdata <= DEF_WIDTH'(req_wdata[w_win]);
      end
      if (r_state == RESP && !r_req.we)
        r_rdata[r_req.idx] <= mem_dout;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 32x256 registered-read RAM model.
module tb_ram_arbiter;
  logic              clk;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][7:0]   req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0][31:0]  rsp_rdata;
  logic              mem_we;
  logic [7:0]        mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic              busy;

  logic [31:0]       ram [256];
  logic              ram_clr;
  int                checks;
  int                failures;
  bit                done;

  ram_arbiter #(.WIDTH(32), .AW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      mem_dout <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Runs one transaction whose request inputs are already driven.
  task automatic txn(input string tag, input logic [1:0] g, input logic we,
                     input logic [7:0] a, input logic [31:0] din,
                     input logic [31:0] rd, input bit drop);
    logic idx;
    idx = g[1];
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, g);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    next_cycle();
    if (drop) req_valid = req_valid & ~g;
    @(negedge clk);
    chk({tag, "_acc_we"}, mem_we, we);
    chk({tag, "_acc_addr"}, mem_addr, a);
    chk({tag, "_acc_din"}, mem_din, din);
    chk({tag, "_acc_ready"}, req_ready, 2'b00);
    chk({tag, "_acc_rsp"}, rsp_valid, 2'b00);
    chk({tag, "_acc_busy"}, busy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk({tag, "_rsp_valid"}, rsp_valid, g);
    chk({tag, "_rsp_we"}, mem_we, 1'b0);
    chk({tag, "_rsp_ready"}, req_ready, 2'b00);
    chk({tag, "_rsp_rdata"}, rsp_rdata[idx], rd);
    next_cycle();
  endtask

  initial begin
    done = 1'b0;
    #100000;
    if (!done) begin
      failures++;
      $error("FAIL timeout waiting for test completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    ram_clr   = 1'b1;
    rst       = 1'b1;
    req_valid = 2'b11;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
    next_cycle();
    next_cycle();
    ram_clr = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_din", mem_din, 32'h0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 64'h0);
    next_cycle();
    rst       = 1'b0;
    req_valid = 2'b00;
    next_cycle();

    // Single write from requester 0.
    req_we[0]    = 1'b1;
    req_addr[0]  = 8'h22;
    req_wdata[0] = 32'hDEADBEEF;
    req_valid    = 2'b01;
    txn("wr0", 2'b01, 1'b1, 8'h22, 32'hDEADBEEF, 32'h0, 1'b1);
    @(negedge clk);
    chk("idle_hold_addr", mem_addr, 8'h22);
    chk("idle_hold_we", mem_we, 1'b0);
    next_cycle();

    // Read-back from requester 1.
    req_we[1]    = 1'b0;
    req_addr[1]  = 8'h22;
    req_wdata[1] = 32'h0;
    req_valid    = 2'b10;
    txn("rd1", 2'b10, 1'b0, 8'h22, 32'h0, 32'hDEADBEEF, 1'b1);

    // Contention right after reset: requester 0 first.
    do_reset();
    req_we       = 2'b11;
    req_addr[0]  = 8'h14;
    req_addr[1]  = 8'h14;
    req_wdata[0] = 32'h11111111;
    req_wdata[1] = 32'h22222222;
    req_valid    = 2'b11;
    txn("ct0", 2'b01, 1'b1, 8'h14, 32'h11111111, 32'h0, 1'b1);
    txn("ct1", 2'b10, 1'b1, 8'h14, 32'h22222222, 32'h0, 1'b1);
    req_we[0]    = 1'b0;
    req_wdata[0] = 32'h0;
    req_valid    = 2'b01;
    txn("ct_rd", 2'b01, 1'b0, 8'h14, 32'h0, 32'h22222222, 1'b1);

    // Sustained contention alternates grants.
    do_reset();
    req_we       = 2'b00;
    req_addr[0]  = 8'h14;
    req_addr[1]  = 8'h22;
    req_wdata    = '0;
    req_valid    = 2'b11;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0)
        txn($sformatf("rr%0d", k), 2'b01, 1'b0, 8'h14, 32'h0, 32'h22222222, 1'b0);
      else
        txn($sformatf("rr%0d", k), 2'b10, 1'b0, 8'h22, 32'h0, 32'hDEADBEEF, 1'b0);
    end
    req_valid = 2'b00;
    next_cycle();

    // Reset during ACCESS of a write aborts it.
    req_we[0]    = 1'b1;
    req_addr[0]  = 8'h4F;
    req_wdata[0] = 32'hA5A5A5A5;
    req_valid    = 2'b01;
    @(negedge clk);
    chk("ab_ready", req_ready, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    rst       = 1'b1;
    @(negedge clk);
    chk("ab_mem_we", mem_we, 1'b0);
    chk("ab_ready_rst", req_ready, 2'b00);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("ab_rsp0", rsp_valid, 2'b00);
    chk("ab_busy", busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("ab_rsp1", rsp_valid, 2'b00);
    next_cycle();
    req_we[1]    = 1'b0;
    req_addr[1]  = 8'h4F;
    req_wdata[1] = 32'h0;
    req_valid    = 2'b10;
    txn("ab_rd", 2'b10, 1'b0, 8'h4F, 32'h0, 32'h0, 1'b1);

    // Quiet bus.
    req_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d", c), {busy, mem_we, req_ready, rsp_valid}, 6'b0);
      next_cycle();
    end

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter AW, default 8, address width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have ports req_valid[i], input, 1, request present on requester i (i = 0,1).
REQ-006 SHALL have ports req_ready[i], output, 1, request accepted this cycle.
REQ-007 SHALL have ports req_we[i], input, 1, 1 = write, 0 = read.
REQ-008 SHALL have ports req_addr[i], input, AW, word address.
REQ-009 SHALL have ports req_wdata[i], input, WIDTH, write data.
REQ-010 SHALL have ports rsp_valid[i], output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports rsp_rdata[i], output, WIDTH, read data, meaningful only with rsp_valid[i] for a read.
REQ-012 SHALL have port mem_we, output, 1, RAM write enable.
REQ-013 SHALL have port mem_addr, output, AW, RAM address.
REQ-014 SHALL have port mem_din, output, WIDTH, RAM write data.
REQ-015 SHALL have port mem_dout, input, WIDTH, RAM read data; valid the cycle after mem_addr is presented.
REQ-016 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 In IDLE, req_ready SHALL be asserted combinationally to exactly one requester with req_valid high, and to none if neither is valid.
REQ-019 Both valid in IDLE: grant SHALL go to the requester not granted at the last accepted handshake (round-robin).
REQ-020 One valid in IDLE: that requester SHALL be granted regardless of the pointer.
REQ-021 On handshake (valid & ready), SHALL register the grant index, we, addr and wdata, update the pointer to the winner, and go to ACCESS.
REQ-022 ACCESS (cycle N+1 after handshake cycle N): SHALL drive mem_addr and mem_din from the registers, and assert mem_we for exactly this cycle only if the request is a write; next state RESP.
REQ-023 RESP (cycle N+2): SHALL pulse rsp_valid of the granted requester only, drive rsp_rdata from mem_dout for reads, and return to IDLE.
REQ-024 For writes, rsp_valid SHALL also pulse at N+2, with rsp_rdata holding its previous value.
REQ-025 Throughput SHALL be at most one transaction per 3 cycles; a new handshake SHALL be possible in the cycle after RESP.
REQ-026 req_ready SHALL be 0 in ACCESS and RESP.
REQ-027 A requester SHALL hold req_* stable while valid & !ready; the arbiter need not sample them before the handshake.
REQ-028 rsp_* SHALL have no backpressure; the requester SHALL accept the pulse.
REQ-029 mem_we SHALL be 0 in every state other than ACCESS-with-write; mem_addr and mem_din SHALL hold their last values when idle.
REQ-030 rsp_rdata[i] SHALL hold its value until the next read response to requester i.

Reset
REQ-031 While rst is high at a clock edge: state SHALL be IDLE, mem_we 0, rsp_valid 0, busy 0, mem_addr 0, mem_din 0, rsp_rdata 0, and the pointer set so that requester 0 wins the first contention.
REQ-032 rst asserted in ACCESS or RESP SHALL abort the transaction with no rsp_valid pulse; a write in ACCESS at the reset edge SHALL be suppressed (mem_we 0).
REQ-033 req_ready SHALL be 0 in any cycle with rst high.

Structure
REQ-034 Package ram_arb_pkg SHALL hold: default WIDTH/AW constants, the FSM state enum (IDLE, ACCESS, RESP), and the registered-request struct (idx, we, addr, wdata).
REQ-035 Round-robin selection SHALL be a sub-module rr_arb2 (inputs: 2-bit valid, pointer; output: one-hot grant); the FSM and datapath registers SHALL stay in ram_arbiter.
REQ-036 The bench SHALL connect the mem_* ports to a 32x256 synchronous RAM model with registered read.

Verification
REQ-037 Single write: req0 writes 0xDEADBEEF to addr 0x22. Required: req_ready0 in cycle N; mem_we high only at N+1 with mem_addr 0x22; rsp_valid0 at N+2.
REQ-038 Read-back: req1 reads addr 0x22 after REQ-037. Required: rsp_valid1 at N+2 with rsp_rdata1 = 0xDEADBEEF; rsp_valid0 stays 0.
REQ-039 Contention after reset: both valid, writing 0x11111111 and 0x22222222 to addr 0x14. Required: req0 granted first, then req1 three cycles later; a following read of 0x14 returns 0x22222222.
REQ-040 Sustained contention: both hold valid for 6 transactions. Required: grants alternate 0,1,0,1,0,1; no requester is granted twice in a row.
REQ-041 Reset mid-op: assert rst during ACCESS of a write of 0xA5A5A5A5 to addr 0x4F. Required: mem_we 0 at that edge, no rsp_valid, and a later read of 0x4F does not return 0xA5A5A5A5 (location pre-filled with 0).
REQ-042 Idle: no req_valid for 20 cycles. Required: busy 0, mem_we 0, both req_ready 0, no rsp_valid.
